pipe_ctrl_chain: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 48 ++++
 rtl/pipe_ctrl_stage.sv | 67 ++++++
 rtl/pipe_ctrl_chain.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl_chain.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the control-bundle pipeline chain:
//   - bit positions of the fields inside the 13-bit control bundle
//   - stage index names (EX, MEM, WB, RET)
//   - per-stage keep masks matching the current CPU, so each stage only
//     carries the enables its consumers still need
package pipe_ctrl_pkg;

  localparam int WIDTH_CTRL   = 13;
  localparam int N_STAGES_CPU = 4;

  // Control bundle layout: opcode[3:0] followed by nine single-bit enables
  localparam int OPC_LSB     = 0;
  localparam int OPC_MSB     = 3;
  localparam int B_SETCC_BIT = 4;
  localparam int B_SHIFT_BIT = 5;
  localparam int B_LOAD_BIT  = 6;
  localparam int B_RF_BIT    = 7;
  localparam int B_SIZE_BIT  = 8;
  localparam int B_RW_BIT    = 9;
  localparam int B_EN_BIT    = 10;
  localparam int B_BL_BIT    = 11;
  localparam int B_INSTR_BIT = 12;

  // Stage indices; stage 0 sits nearest the control unit
  localparam int ST_EX  = 0;
  localparam int ST_MEM = 1;
  localparam int ST_WB  = 2;
  localparam int ST_RET = 3;

  typedef logic [WIDTH_CTRL-1:0] ctrl_t;

  // EX consumes the whole bundle; MEM only needs the memory-side enables
  // plus the register-file write; WB and retire only need the RF write.
  localparam ctrl_t KEEP_EX  = '1;
  localparam ctrl_t KEEP_MEM = (ctrl_t'(1) << B_LOAD_BIT) |
                               (ctrl_t'(1) << B_RF_BIT)   |
                               (ctrl_t'(1) << B_SIZE_BIT) |
                               (ctrl_t'(1) << B_RW_BIT)   |
                               (ctrl_t'(1) << B_EN_BIT);
  localparam ctrl_t KEEP_WB  = (ctrl_t'(1) << B_RF_BIT);
  localparam ctrl_t KEEP_RET = (ctrl_t'(1) << B_RF_BIT);

  // Packed with stage 0 in the least significant slice
  localparam logic [N_STAGES_CPU*WIDTH_CTRL-1:0] KEEP_MASK_CPU =
    {KEEP_RET, KEEP_WB, KEEP_MEM, KEEP_EX};

endpackage

// File: rtl/pipe_ctrl_stage.sv
// pipe_ctrl_stage
// One control pipeline register (WIDTH bundle bits + valid).
// Update priority: reset, flush, hold, bubble, load.
// Ports:
//   clk_i     clock
//   r_i       synchronous active-high reset
//   flush_i   clear this stage (wins over hold)
//   hold_i    keep current contents
//   bubble_i  load an empty slot instead of the upstream data
//   ctrl_i    upstream bundle
//   valid_i   upstream valid
//   ctrl_o    registered bundle, masked with KEEP
//   valid_o   registered valid
module pipe_ctrl_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int               WIDTH = WIDTH_CTRL,
  parameter logic [WIDTH-1:0] KEEP  = '1
) (
  input  logic             clk_i,
  input  logic             r_i,
  input  logic             flush_i,
  input  logic             hold_i,
  input  logic             bubble_i,
  input  logic [WIDTH-1:0] ctrl_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] ctrl_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] ctrl_q, ctrl_d;
  logic             valid_q, valid_d;

  // Masking happens only on load; hold recirculates an already-masked
  // value and flush/bubble write zero, so masked bits never become 1.
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (flush_i) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (hold_i) begin
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
    end else if (bubble_i) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else begin
      ctrl_d  = ctrl_i & KEEP;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_i) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain
// Chain of STAGES control registers between the control unit and the
// EX/MEM/WB consumers, with stall-driven bubble insertion, per-stage
// flush, per-stage field masking and a saturating retired-bubble counter.
// Ports:
//   clk         clock
//   R           synchronous active-high reset
//   LE          global load enable (0 holds every stage)
//   in_ctrl     bundle from the control unit
//   in_valid    in_ctrl is a real instruction
//   nop_sel     inject a bubble into stage 0
//   stall       stall[i] holds stage i and everything upstream
//   flush       flush[i] clears stage i
//   cnt_clr     synchronous clear of bubble_cnt
//   out_ctrl    stage i bundle at [i*WIDTH +: WIDTH]
//   out_valid   valid bit per stage
//   bubble_cnt  number of bubbles that reached the last stage (saturating)
module pipe_ctrl_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int                      WIDTH     = WIDTH_CTRL,
  parameter int                      STAGES    = 4,
  parameter logic [STAGES*WIDTH-1:0] KEEP_MASK = '1,
  parameter int                      CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    R,
  input  logic                    LE,
  input  logic [WIDTH-1:0]        in_ctrl,
  input  logic                    in_valid,
  input  logic                    nop_sel,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  input  logic                    cnt_clr,
  output logic [STAGES*WIDTH-1:0] out_ctrl,
  output logic [STAGES-1:0]       out_valid,
  output logic [CNT_W-1:0]        bubble_cnt
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] bubble;
  logic [WIDTH-1:0]  stage_ctrl [STAGES];
  logic [STAGES-1:0] stage_valid;
  logic              retire_bubble;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // A stall anywhere downstream freezes this stage too, so the hold for
  // stage i is the OR of stall[i..LAST]; a shift keeps exactly those bits.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      hold[i] = ~LE | (|(stall >> i));
    end
  end

  // Stage 0 takes its bubble from the CU mux select; later stages take a
  // bubble whenever the stage feeding them is frozen.
  always_comb begin
    bubble[0] = nop_sel;
    for (int i = 1; i < STAGES; i++) begin
      bubble[i] = hold[i-1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [WIDTH-1:0] src_ctrl;
    logic             src_valid;

    if (i == 0) begin : g_head
      assign src_ctrl  = in_ctrl;
      assign src_valid = in_valid;
    end else begin : g_body
      assign src_ctrl  = stage_ctrl[i-1];
      assign src_valid = stage_valid[i-1];
    end

    pipe_ctrl_stage #(
      .WIDTH (WIDTH),
      .KEEP  (KEEP_MASK[i*WIDTH +: WIDTH])
    ) u_stage (
      .clk_i    (clk),
      .r_i      (R),
      .flush_i  (flush[i]),
      .hold_i   (hold[i]),
      .bubble_i (bubble[i]),
      .ctrl_i   (src_ctrl),
      .valid_i  (src_valid),
      .ctrl_o   (stage_ctrl[i]),
      .valid_o  (stage_valid[i])
    );

    assign out_ctrl[i*WIDTH +: WIDTH] = stage_ctrl[i];
  end

  assign out_valid = stage_valid;

  // The last stage "loads" whenever it is flushed or not held; the loaded
  // slot is empty if it was flushed, bubbled, or the upstream slot was empty.
  assign retire_bubble = flush[LAST] |
                         (~hold[LAST] & (hold[LAST-1] | ~stage_valid[LAST-1]));

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (retire_bubble && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb_pipe_ctrl_chain
// Directed scenarios for pipe_ctrl_chain (WIDTH=13, STAGES=4, CPU keep masks).
// A reference model predicts the state after every edge and queues it; a
// monitor pops and compares on each falling edge. Hand-computed checkpoints
// are compared inline after specific edges.
module tb_pipe_ctrl_chain;
  import pipe_ctrl_pkg::*;

  localparam int W = WIDTH_CTRL;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           R, LE, in_valid, nop_sel, cnt_clr;
  logic [W-1:0]   in_ctrl;
  logic [S-1:0]   stall, flush;
  logic [S*W-1:0] out_ctrl, out_ctrl2;
  logic [S-1:0]   out_valid, out_valid2;
  logic [15:0]    bubble_cnt;
  logic [1:0]     bubble_cnt2;

  pipe_ctrl_chain #(.WIDTH(W), .STAGES(S), .KEEP_MASK(KEEP_MASK_CPU), .CNT_W(16)) dut (
    .clk(clk), .R(R), .LE(LE), .in_ctrl(in_ctrl), .in_valid(in_valid),
    .nop_sel(nop_sel), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .out_ctrl(out_ctrl), .out_valid(out_valid), .bubble_cnt(bubble_cnt));

  pipe_ctrl_chain #(.WIDTH(W), .STAGES(S), .KEEP_MASK(KEEP_MASK_CPU), .CNT_W(2)) dut2 (
    .clk(clk), .R(R), .LE(LE), .in_ctrl(in_ctrl), .in_valid(in_valid),
    .nop_sel(nop_sel), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .out_ctrl(out_ctrl2), .out_valid(out_valid2), .bubble_cnt(bubble_cnt2));

  // Reference masks written out independently: EX all, MEM bits 6..10, WB/RET bit 7
  logic [W-1:0] mask [S] = '{13'h1FFF, 13'h07C0, 13'h0080, 13'h0080};

  logic [W-1:0] m_ctrl [S];
  logic [S-1:0] m_valid;
  int unsigned  m_cnt, m_cnt2;

  typedef struct {
    logic [S*W-1:0] ctrl;
    logic [S-1:0]   valid;
    logic [15:0]    cnt;
    logic [1:0]     cnt2;
  } exp_t;
  exp_t sbq [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] st_ctrl(input int i);
    return out_ctrl[i*W +: W];
  endfunction

  // Advance the model by one edge using the currently driven inputs
  task automatic model_step();
    logic [W-1:0] nc [S];
    logic [S-1:0] nv;
    logic [S-1:0] hold;
    logic         retire;
    if (R) begin
      for (int i = 0; i < S; i++) m_ctrl[i] = '0;
      m_valid = '0;
      m_cnt = 0;
      m_cnt2 = 0;
      return;
    end
    for (int i = 0; i < S; i++) begin
      hold[i] = !LE;
      for (int j = i; j < S; j++) hold[i] = hold[i] | stall[j];
    end
    for (int i = 0; i < S; i++) begin
      if (flush[i]) begin
        nc[i] = '0; nv[i] = 1'b0;
      end else if (hold[i]) begin
        nc[i] = m_ctrl[i]; nv[i] = m_valid[i];
      end else if ((i == 0) ? nop_sel : hold[i-1]) begin
        nc[i] = '0; nv[i] = 1'b0;
      end else if (i == 0) begin
        nc[i] = in_ctrl & mask[i]; nv[i] = in_valid;
      end else begin
        nc[i] = m_ctrl[i-1] & mask[i]; nv[i] = m_valid[i-1];
      end
    end
    retire = (flush[S-1] || !hold[S-1]) && !nv[S-1];
    if (cnt_clr) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (retire) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    for (int i = 0; i < S; i++) m_ctrl[i] = nc[i];
    m_valid = nv;
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic step(input logic [W-1:0] c, input logic v, input logic nop = 1'b0,
                      input logic [S-1:0] st = '0, input logic [S-1:0] fl = '0,
                      input logic le = 1'b1, input logic clr = 1'b0, input logic r = 1'b0);
    exp_t e;
    in_ctrl = c; in_valid = v; nop_sel = nop; stall = st; flush = fl;
    LE = le; cnt_clr = clr; R = r;
    model_step();
    for (int i = 0; i < S; i++) e.ctrl[i*W +: W] = m_ctrl[i];
    e.valid = m_valid;
    e.cnt   = 16'(m_cnt);
    e.cnt2  = 2'(m_cnt2);
    @(posedge clk);
    sbq.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare every post-edge state against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_ctrl",   out_ctrl,    e.ctrl);
        chk("sb_valid",  out_valid,   e.valid);
        chk("sb_cnt",    bubble_cnt,  e.cnt);
        chk("sb_ctrl2",  out_ctrl2,   e.ctrl);
        chk("sb_valid2", out_valid2,  e.valid);
        chk("sb_cnt2",   bubble_cnt2, e.cnt2);
      end
    end
  end

  initial begin
    for (int i = 0; i < S; i++) m_ctrl[i] = '0;
    m_valid = '0; m_cnt = 0; m_cnt2 = 0;
    R = 1'b1; LE = 1'b1; in_ctrl = '0; in_valid = 1'b0; nop_sel = 1'b0;
    stall = '0; flush = '0; cnt_clr = 1'b0;
    @(negedge clk);

    // Reset with an all-ones valid bundle on the input
    step(13'h1FFF, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(13'h1FFF, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    chk("rst_ctrl",  out_ctrl,   '0);
    chk("rst_valid", out_valid,  '0);
    chk("rst_cnt",   bubble_cnt, '0);

    // Latency and masking
    step(13'h0A5, 1'b1);
    chk("lat_e1_s0",  st_ctrl(0), 13'h0A5);
    chk("lat_e1_vld", out_valid,  4'b0001);
    chk("lat_e1_cnt", bubble_cnt, 16'd1);
    step(13'h123, 1'b1);
    chk("lat_e2_s0", st_ctrl(0), 13'h123);
    chk("lat_e2_s1", st_ctrl(1), 13'h080);
    step(13'h1C0, 1'b1);
    chk("lat_e3_s1", st_ctrl(1), 13'h100);
    chk("lat_e3_s2", st_ctrl(2), 13'h080);
    step(13'h000, 1'b0);
    chk("lat_e4_s3",  st_ctrl(3), 13'h080);
    chk("lat_e4_s2",  st_ctrl(2), 13'h000);
    chk("lat_e4_s1",  st_ctrl(1), 13'h1C0);
    chk("lat_e4_vld", out_valid,  4'b1110);
    chk("lat_e4_cnt", bubble_cnt, 16'd3);

    // Fill, clearing the counter on the last fill edge
    step(13'h001, 1'b1);
    step(13'h002, 1'b1);
    step(13'h1C0, 1'b1);
    step(13'h0F0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1);
    chk("fill_cnt_clr", bubble_cnt, 16'd0);

    // stall[1] for two cycles
    step(13'h0AA, 1'b1, 1'b0, 4'b0010);
    step(13'h0AA, 1'b1, 1'b0, 4'b0010);
    chk("stall_s0",  st_ctrl(0), 13'h0F0);
    chk("stall_s1",  st_ctrl(1), 13'h1C0);
    chk("stall_vld", out_valid,  4'b0011);
    chk("stall_cnt", bubble_cnt, 16'd1);
    step(13'h0AA, 1'b1);
    chk("stall_rel_s2",  st_ctrl(2), 13'h080);
    chk("stall_rel_cnt", bubble_cnt, 16'd2);
    step(13'h0BB, 1'b1);
    chk("stall_ret_s3",  st_ctrl(3), 13'h080);
    chk("stall_ret_cnt", bubble_cnt, 16'd2);

    // stall[2] and flush[2] together
    step(13'h081, 1'b1);
    step(13'h1FF, 1'b1);
    step(13'h333, 1'b1);
    step(13'h444, 1'b1);
    step(13'h555, 1'b1, 1'b0, 4'b0100, 4'b0100);
    chk("fs_s0",  st_ctrl(0), 13'h444);
    chk("fs_s1",  st_ctrl(1), 13'h300);
    chk("fs_s2",  st_ctrl(2), 13'h000);
    chk("fs_s3",  st_ctrl(3), 13'h000);
    chk("fs_vld", out_valid,  4'b0011);

    // nop_sel for three cycles with in_valid=1
    step(13'h0F1, 1'b1);
    step(13'h0F2, 1'b1);
    step(13'h0F3, 1'b1);
    step(13'h0F4, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1);
    chk("nop_pre_cnt", bubble_cnt, 16'd0);
    for (int k = 0; k < 3; k++) step(13'h1FF, 1'b1, 1'b1);
    chk("nop_vld", out_valid,  4'b1000);
    chk("nop_cnt0", bubble_cnt, 16'd0);
    step(13'h0A0, 1'b1);
    chk("nop_cnt1", bubble_cnt, 16'd1);
    step(13'h0A0, 1'b1);
    chk("nop_cnt2", bubble_cnt, 16'd2);
    step(13'h0A0, 1'b1);
    chk("nop_cnt3", bubble_cnt, 16'd3);

    // Saturation on the 2-bit counter
    step(13'h0A0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) step(13'h000, 1'b0);
    chk("sat_cnt16", bubble_cnt,  16'd5);
    chk("sat_cnt2",  bubble_cnt2, 2'd3);

    // Clear concurrent with a retiring bubble
    step(13'h000, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    chk("clr_bub_cnt16", bubble_cnt,  16'd0);
    chk("clr_bub_cnt2",  bubble_cnt2, 2'd0);

    // LE=0 freezes stages and counter; flush of the last stage still counts
    step(13'h0C3, 1'b1);
    chk("le_pre_cnt", bubble_cnt, 16'd1);
    step(13'h155, 1'b1, 1'b0, '0, '0, 1'b0);
    chk("le0_s0",  st_ctrl(0), 13'h0C3);
    chk("le0_cnt", bubble_cnt, 16'd1);
    step(13'h155, 1'b1, 1'b0, '0, 4'b1000, 1'b0);
    chk("le0_fl_s0",  st_ctrl(0), 13'h0C3);
    chk("le0_fl_cnt", bubble_cnt, 16'd2);

    // Reset in the middle of stall and flush
    step(13'h155, 1'b1, 1'b0, 4'b0001, 4'b0010, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_ctrl",  out_ctrl,   '0);
    chk("rst_mid_valid", out_valid,  '0);
    chk("rst_mid_cnt",   bubble_cnt, '0);

    step(13'h1AB, 1'b1);
    step(13'h000, 1'b0);
    @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
